// File: rtl/task_reg_pkg.sv
// Shared definitions for the task request bank: channel state encoding,
// default register addresses and the timeout counter width.
package task_reg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_LO = 2'd2
  } chan_state_t;

  localparam logic [11:0] DEF_TASK_ADR = 12'hffe;
  localparam logic [11:0] DEF_OVF_ADR  = 12'hffd;
  localparam logic [11:0] DEF_TMO_ADR  = 12'hffc;

  // Counter must hold 0..timeout; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/task_chan.sv
// One task channel: four-phase req/ack FSM with a one-deep re-trigger queue,
// an optional ack timeout and single-cycle overflow/timeout set pulses.
module task_chan
  import task_reg_pkg::*;
#(
  parameter int P_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic val,
  output logic ovf_set,
  output logic tmo_set
);

  localparam int CW = cnt_width(P_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  chan_state_t   state_reg, state_next;
  logic          pending_reg, pending_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      pending_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    cnt_next     = cnt_reg;
    ovf_set      = 1'b0;
    tmo_set      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = REQ;
          cnt_next   = '0;
        end
      end
      REQ: begin
        if (ack) begin
          state_next = WAIT_LO;
        end else if ((P_TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
          state_next = WAIT_LO;
          tmo_set    = 1'b1;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CW'(1);
        end
        if (start) begin
          if (pending_reg) ovf_set = 1'b1;
          else             pending_next = 1'b1;
        end
      end
      WAIT_LO: begin
        if (!ack && (pending_reg || start)) begin
          state_next   = REQ;
          cnt_next     = '0;
          // The queued request is consumed; a start in the same cycle re-queues.
          pending_next = pending_reg && start;
        end else if (!ack) begin
          state_next = IDLE;
        end else if (start) begin
          if (pending_reg) ovf_set = 1'b1;
          else             pending_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req = (state_reg == REQ);
  assign val = (state_reg != IDLE) || pending_reg;

endmodule

// File: rtl/task_req_bank.sv
// Bank of task channels behind the register bus: trigger decode, sticky
// overflow/timeout status with write-1-to-clear, and registered readback.
module task_req_bank
  import task_reg_pkg::*;
#(
  parameter int                 P_N_TASK   = 16,
  parameter int                 P_ADR_W    = 12,
  parameter int                 P_DATA_W   = 16,
  parameter logic [P_ADR_W-1:0] P_TASK_ADR = DEF_TASK_ADR,
  parameter logic [P_ADR_W-1:0] P_OVF_ADR  = DEF_OVF_ADR,
  parameter logic [P_ADR_W-1:0] P_TMO_ADR  = DEF_TMO_ADR,
  parameter int                 P_TIMEOUT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [P_ADR_W-1:0]  adr,
  input  logic                wr,
  input  logic [P_DATA_W-1:0] data,
  output logic [P_DATA_W-1:0] rd_data,
  output logic [P_N_TASK-1:0] req,
  input  logic [P_N_TASK-1:0] ack,
  output logic [P_N_TASK-1:0] val,
  output logic                busy
);

  logic [P_N_TASK-1:0] start, ovf_set, tmo_set, ovf_clr, tmo_clr;
  logic [P_N_TASK-1:0] ovf_reg, tmo_reg;

  assign start   = (wr && (adr == P_TASK_ADR)) ? data[P_N_TASK-1:0] : '0;
  assign ovf_clr = (wr && (adr == P_OVF_ADR))  ? data[P_N_TASK-1:0] : '0;
  assign tmo_clr = (wr && (adr == P_TMO_ADR))  ? data[P_N_TASK-1:0] : '0;

  generate
    for (genvar gi = 0; gi < P_N_TASK; gi++) begin : g_chan
      task_chan #(
        .P_TIMEOUT(P_TIMEOUT)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .start   (start[gi]),
        .ack     (ack[gi]),
        .req     (req[gi]),
        .val     (val[gi]),
        .ovf_set (ovf_set[gi]),
        .tmo_set (tmo_set[gi])
      );
    end
  endgenerate

  // Set terms are OR-ed after the clear so a same-cycle set survives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_reg <= '0;
      tmo_reg <= '0;
      rd_data <= '0;
    end else begin
      ovf_reg <= (ovf_reg & ~ovf_clr) | ovf_set;
      tmo_reg <= (tmo_reg & ~tmo_clr) | tmo_set;
      if (adr == P_OVF_ADR)      rd_data <= P_DATA_W'(ovf_reg);
      else if (adr == P_TMO_ADR) rd_data <= P_DATA_W'(tmo_reg);
      else                       rd_data <= '0;
    end
  end

  assign busy = |val;

endmodule

// File: tb/tb_task_req_bank.sv
// Directed bench for task_req_bank: cycle tables for the handshake paths plus
// hand sequences for overflow, timeout and reset corners.
module tb_task_req_bank;

  localparam logic [11:0] TASK_ADR = 12'hffe;
  localparam logic [11:0] OVF_ADR  = 12'hffd;
  localparam logic [11:0] TMO_ADR  = 12'hffc;
  localparam logic [11:0] NO_ADR   = 12'h000;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] adr;
  logic        wr;
  logic [15:0] data;
  logic [15:0] ack;

  logic [15:0] rd8, req8, val8;
  logic        busy8;
  logic [15:0] rd0, req0, val0;
  logic        busy0;

  always #5 clk = ~clk;

  task_req_bank #(.P_TIMEOUT(8)) u_t8 (
    .clk(clk), .rst(rst), .adr(adr), .wr(wr), .data(data),
    .rd_data(rd8), .req(req8), .ack(ack), .val(val8), .busy(busy8)
  );

  task_req_bank #(.P_TIMEOUT(0)) u_t0 (
    .clk(clk), .rst(rst), .adr(adr), .wr(wr), .data(data),
    .rd_data(rd0), .req(req0), .ack(ack), .val(val0), .busy(busy0)
  );

  typedef struct {
    logic        wr;
    logic [11:0] adr;
    logic [15:0] data;
    logic [15:0] ack;
    logic [15:0] exp_req;
    logic [15:0] exp_val;
    logic        exp_busy;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [11:0] a, input logic [15:0] d, input logic [15:0] k);
    wr   = w;
    adr  = a;
    data = d;
    ack  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic w, input logic [11:0] a, input logic [15:0] d, input logic [15:0] k,
                     input logic [15:0] er, input logic [15:0] ev, input logic eb, input logic [15:0] erd);
    vec_t v;
    v.wr = w; v.adr = a; v.data = d; v.ack = k;
    v.exp_req = er; v.exp_val = ev; v.exp_busy = eb; v.exp_rd = erd;
    vq.push_back(v);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].wr, vq[i].adr, vq[i].data, vq[i].ack);
      $display("%s[%0d] wr=%0b adr=%h data=%h ack=%h -> req=%h val=%h busy=%0b rd=%h",
               name, i, vq[i].wr, vq[i].adr, vq[i].data, vq[i].ack, req8, val8, busy8, rd8);
      check($sformatf("%s[%0d].req", name, i), req8, vq[i].exp_req);
      check($sformatf("%s[%0d].val", name, i), val8, vq[i].exp_val);
      check($sformatf("%s[%0d].busy", name, i), {15'd0, busy8}, {15'd0, vq[i].exp_busy});
      check($sformatf("%s[%0d].rd", name, i), rd8, vq[i].exp_rd);
    end
    vq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(1'b0, NO_ADR, 16'h0000, 16'h0000);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] m;

    // Reset held with a live trigger write on the bus.
    rst = 1'b0;
    wr = 1'b1; adr = TASK_ADR; data = 16'hffff; ack = 16'h0000;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    $display("reset: req=%h val=%h busy=%0b rd=%h", req8, val8, busy8, rd8);
    check("rst.req8", req8, 16'h0000);
    check("rst.val8", val8, 16'h0000);
    check("rst.busy8", {15'd0, busy8}, 16'h0000);
    check("rst.rd8", rd8, 16'h0000);
    check("rst.req0", req0, 16'h0000);
    check("rst.val0", val0, 16'h0000);
    rst = 1'b1;

    // After release: idle, ack outside REQ ignored, then an all-channel write.
    add(0, NO_ADR,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'hffff, 16'h0000, 16'h0000, 0, 16'h0000);
    add(1, TASK_ADR, 16'hffff, 16'h0000, 16'hffff, 16'hffff, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'hffff, 16'h0000, 16'hffff, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    run_table("post_rst");

    // Single task per bit, ack echoing req one cycle later.
    for (int b = 0; b < 16; b++) begin
      m = 16'h0001 << b;
      add(1, TASK_ADR, m,        16'h0000, m,        m,        1, 16'h0000);
      add(0, NO_ADR,   16'h0000, 16'h0000, m,        m,        1, 16'h0000);
      add(0, NO_ADR,   16'h0000, m,        16'h0000, m,        1, 16'h0000);
      add(0, NO_ADR,   16'h0000, m,        16'h0000, m,        1, 16'h0000);
      add(0, NO_ADR,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
      run_table($sformatf("single%0d", b));
    end

    // Overlapping writes 0001 then 0003; ack is the one-cycle echo of req.
    add(1, TASK_ADR, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 1, 16'h0000);
    add(1, TASK_ADR, 16'h0003, 16'h0000, 16'h0003, 16'h0003, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'h0001, 16'h0002, 16'h0003, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'h0003, 16'h0000, 16'h0003, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'h0002, 16'h0001, 16'h0003, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'h0000, 16'h0001, 16'h0001, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'h0001, 16'h0000, 16'h0001, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'h0001, 16'h0000, 16'h0001, 1, 16'h0000);
    add(0, NO_ADR,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, OVF_ADR,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    add(0, TMO_ADR,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    run_table("overlap");

    // Overflow on the no-timeout instance: three writes to channel 3, no ack.
    cyc(1'b1, TASK_ADR, 16'h0008, 16'h0000);
    $display("ovf write1: req0=%h val0=%h", req0, val0);
    check("ovf.w1.req0", req0, 16'h0008);
    cyc(1'b1, TASK_ADR, 16'h0008, 16'h0000);
    $display("ovf write2: req0=%h val0=%h", req0, val0);
    check("ovf.w2.val0", val0, 16'h0008);
    cyc(1'b1, TASK_ADR, 16'h0008, 16'h0000);
    $display("ovf write3: req0=%h val0=%h", req0, val0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, NO_ADR, 16'h0000, 16'h0000);
      if (req0 !== 16'h0008) n++;
    end
    $display("ovf hold: req0=%h after 20 cycles, %0d off-cycles", req0, n);
    check("ovf.hold_off_cycles", n[15:0], 16'h0000);
    cyc(1'b0, OVF_ADR, 16'h0000, 16'h0000);
    $display("ovf read: rd0=%h", rd0);
    check("ovf.rd_ovf", rd0, 16'h0008);
    cyc(1'b0, TASK_ADR, 16'h0000, 16'h0000);
    $display("ovf read other adr: rd0=%h", rd0);
    check("ovf.rd_other", rd0, 16'h0000);
    cyc(1'b0, TMO_ADR, 16'h0000, 16'h0000);
    $display("ovf read tmo: rd0=%h", rd0);
    check("ovf.rd_tmo_disabled", rd0, 16'h0000);
    cyc(1'b1, OVF_ADR, 16'h0008, 16'h0000);
    cyc(1'b0, OVF_ADR, 16'h0000, 16'h0000);
    $display("ovf after clear: rd0=%h", rd0);
    check("ovf.rd_cleared", rd0, 16'h0000);
    do_reset();

    // Timeout: req[0] high exactly 8 cycles on the timeout instance.
    cyc(1'b1, TASK_ADR, 16'h0001, 16'h0000);
    n = req8[0] ? 1 : 0;
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, NO_ADR, 16'h0000, 16'h0000);
      if (req8[0]) n++;
    end
    $display("timeout: req[0] high %0d cycles, req0=%h", n, req0);
    check("tmo.req_cycles", n[15:0], 16'h0008);
    check("tmo.no_timeout_inst_req", req0, 16'h0001);
    check("tmo.val_after", val8, 16'h0000);
    cyc(1'b0, TMO_ADR, 16'h0000, 16'h0000);
    $display("timeout read: rd8=%h", rd8);
    check("tmo.rd_tmo", rd8, 16'h0001);
    cyc(1'b1, TMO_ADR, 16'h0001, 16'h0000);
    cyc(1'b0, TMO_ADR, 16'h0000, 16'h0000);
    $display("timeout after clear: rd8=%h", rd8);
    check("tmo.rd_cleared", rd8, 16'h0000);
    do_reset();

    // Ack arriving on the limit cycle wins over the timeout.
    cyc(1'b1, TASK_ADR, 16'h0001, 16'h0000);
    repeat (7) cyc(1'b0, NO_ADR, 16'h0000, 16'h0000);
    $display("limit: req8=%h before ack", req8);
    check("limit.req_before", req8, 16'h0001);
    cyc(1'b0, NO_ADR, 16'h0000, 16'h0001);
    $display("limit: req8=%h after ack", req8);
    check("limit.req_after", req8, 16'h0000);
    cyc(1'b0, TMO_ADR, 16'h0000, 16'h0000);
    $display("limit: rd8=%h val8=%h", rd8, val8);
    check("limit.rd_tmo", rd8, 16'h0000);
    check("limit.val", val8, 16'h0000);
    do_reset();

    // Timeout set coinciding with a write-1-to-clear: the set survives.
    cyc(1'b1, TASK_ADR, 16'h0001, 16'h0000);
    repeat (7) cyc(1'b0, NO_ADR, 16'h0000, 16'h0000);
    cyc(1'b1, TMO_ADR, 16'h0001, 16'h0000);
    cyc(1'b0, TMO_ADR, 16'h0000, 16'h0000);
    $display("set_wins: rd8=%h", rd8);
    check("setwins.rd_tmo", rd8, 16'h0001);
    cyc(1'b1, TMO_ADR, 16'h0001, 16'h0000);
    cyc(1'b0, TMO_ADR, 16'h0000, 16'h0000);
    $display("set_wins after clear: rd8=%h", rd8);
    check("setwins.rd_cleared", rd8, 16'h0000);
    do_reset();

    // Reset mid-handshake with a pending re-trigger on channel 5.
    cyc(1'b1, TASK_ADR, 16'h0020, 16'h0000);
    check("midrst.req_on", req8, 16'h0020);
    cyc(1'b1, TASK_ADR, 16'h0020, 16'h0000);
    $display("midrst before: req8=%h val8=%h", req8, val8);
    check("midrst.val_on", val8, 16'h0020);
    rst = 1'b0;
    cyc(1'b0, NO_ADR, 16'h0000, 16'h0000);
    $display("midrst in reset: req8=%h val8=%h", req8, val8);
    check("midrst.req_off", req8, 16'h0000);
    check("midrst.val_off", val8, 16'h0000);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, NO_ADR, 16'h0000, 16'h0000);
      if ((req8 !== 16'h0000) || (val8 !== 16'h0000)) n++;
    end
    $display("midrst after release: %0d active cycles", n);
    check("midrst.no_reissue", n[15:0], 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
